select_out_fifo: RTL

- Downstream buffer stage for the 8-bit data/valid selector. Captures every selected byte presented with valid high and holds it in a small FIFO.
- Presents the buffered bytes to the consumer with a valid/ready handshake.
- Selector has no backpressure: bytes arriving while the FIFO is full are dropped and flagged with a sticky overflow flag.

---
 rtl/select_out_fifo_pkg.sv | 17 +
 rtl/select_out_fifo_if.sv | 30 +++
 rtl/select_out_fifo_mem.sv | 26 ++
 rtl/select_out_fifo.sv | 71 +++++++
 4 files changed

// File: rtl/select_out_fifo_pkg.sv
// Shared sizing for the selector output buffers: data width, FIFO depth and pointer width.
// Other config-control buffers reuse these constants.
package select_out_fifo_pkg;

  localparam int SOF_DATA_W = 8;
  localparam int SOF_DEPTH  = 8;

  function automatic int sof_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int SOF_ADDR_W = sof_clog2(SOF_DEPTH);

endpackage

// File: rtl/select_out_fifo_if.sv
// Selector-side write bus, consumer valid/ready read bus and status for select_out_fifo.
// The master side drives selector data and consumer ready; the slave side is the FIFO.
interface select_out_fifo_if
  import select_out_fifo_pkg::*;
#(
  parameter int DATA_W = SOF_DATA_W,
  parameter int ADDR_W = SOF_ADDR_W
);

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              in_ready;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_out;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clear_ovf;

  modport master (
    output data_in, valid_in, ready_out, clear_ovf,
    input  in_ready, data_out, valid_out, count, overflow
  );

  modport slave (
    input  data_in, valid_in, ready_out, clear_ovf,
    output in_ready, data_out, valid_out, count, overflow
  );

endinterface

// File: rtl/select_out_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module sel_fifo_mem
  import select_out_fifo_pkg::*;
#(
  parameter int DATA_W = SOF_DATA_W,
  parameter int DEPTH  = SOF_DEPTH,
  parameter int ADDR_W = SOF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/select_out_fifo.sv
// Selector output buffer: first-word-fall-through FIFO, 1 cycle from write to data_out.
// No input backpressure: writes while full (and not popping) are dropped and set sticky overflow.
module select_out_fifo
  import select_out_fifo_pkg::*;
#(
  parameter int DATA_W = SOF_DATA_W,
  parameter int DEPTH  = SOF_DEPTH,
  parameter int ADDR_W = SOF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  select_out_fifo_if.slave   bus
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              full;
  logic              valid_out;
  logic              push;
  logic              pop;
  logic              drop;

  assign full      = (count == CNT_FULL);
  assign valid_out = (count != '0);
  assign pop       = valid_out && bus.ready_out;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the write.
  assign push      = bus.valid_in && (!full || pop);
  assign drop      = bus.valid_in && full && !pop;

  sel_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (bus.data_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
      // A drop in the same cycle as clear_ovf keeps the flag set.
      if (drop)               overflow <= 1'b1;
      else if (bus.clear_ovf) overflow <= 1'b0;
    end
  end

  assign bus.valid_out = valid_out;
  assign bus.in_ready  = !full;
  assign bus.count     = count;
  assign bus.overflow  = overflow;

endmodule
